uart_rx_fifo_driver: RTL and testbench

//   Parametrised UART receive path for the CPU I/O bus: oversampled RX deserialiser with optional parity,
//   an N-deep receive FIFO, sticky error flags and a registered data/status read port.

---
 rtl/uart_rx_fifo_driver.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_fifo_driver.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_driver.sv
// Oversampled UART receiver with optional parity, receive FIFO, sticky error flags
// and a registered data/status read port for the CPU I/O bus.
module uart_rx_fifo_driver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int UART_BPS   = 128000,
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int FIFO_DEPTH = 16,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 uart_rxd,
  input  logic                 rd_en,
  input  logic                 rd_sel,
  input  logic                 clr_err,
  output logic [OUT_WIDTH-1:0] rd_data,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 err_any
);

  localparam int BIT_CNT  = CLK_FREQ / UART_BPS;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int TMR_W    = $clog2(BIT_CNT + 1);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int BIDX_W   = 3;
  localparam int STAT_W   = CNT_W + 5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rxState_t;

  rxState_t               state, stateNext;
  logic                   rxdMeta, rxdS, rxdPrev;
  logic [TMR_W-1:0]       bitTimer;
  logic [BIDX_W-1:0]      bitIdx;
  logic [DATA_BITS-1:0]   shiftReg;
  logic                   parityBad;
  logic                   sampleTick;
  logic                   pushReq, frameErrEvt, parityErrEvt;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wrPtr, rdPtr;
  logic [CNT_W-1:0]       count;
  logic                   doPop, doPush, overrunEvt;
  logic                   overrun, frameErr, parityErr;
  logic [STAT_W-1:0]      statusWord;

  // Parity bit the transmitter should have sent for this payload
  function automatic logic expParity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction

  // Two-flop synchroniser; rxdPrev gives the falling-edge detector its history
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxdMeta <= 1'b1;
      rxdS    <= 1'b1;
      rxdPrev <= 1'b1;
    end else begin
      rxdMeta <= uart_rxd;
      rxdS    <= rxdMeta;
      rxdPrev <= rxdS;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    pushReq      = 1'b0;
    frameErrEvt  = 1'b0;
    parityErrEvt = 1'b0;
    sampleTick   = (state == START) ? (bitTimer == TMR_W'(HALF_CNT - 1))
                                    : (bitTimer == TMR_W'(BIT_CNT - 1));
    case (state)
      IDLE:   if (rxdPrev && !rxdS) stateNext = START;
      START:  if (sampleTick) stateNext = rxdS ? IDLE : DATA;
      DATA:   if (sampleTick && (bitIdx == BIDX_W'(DATA_BITS - 1)))
                stateNext = PARITY_EN ? PARITY : STOP;
      PARITY: if (sampleTick) begin
                stateNext    = STOP;
                parityErrEvt = (rxdS != expParity(shiftReg));
              end
      STOP:   if (sampleTick) begin
                stateNext = IDLE;
                if (!rxdS)           frameErrEvt = 1'b1;
                else if (!parityBad) pushReq     = 1'b1;
              end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bitTimer  <= '0;
      bitIdx    <= '0;
      parityBad <= 1'b0;
    end else begin
      if (state == IDLE || sampleTick) bitTimer <= '0;
      else                             bitTimer <= bitTimer + TMR_W'(1);
      if (state != DATA)   bitIdx <= '0;
      else if (sampleTick) bitIdx <= bitIdx + BIDX_W'(1);
      if (state == START)    parityBad <= 1'b0;
      else if (parityErrEvt) parityBad <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (state == DATA && sampleTick) shiftReg <= {rxdS, shiftReg[DATA_BITS-1:1]};
  end

  // FIFO: a pop in the same cycle frees the slot a full-FIFO push needs
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign doPop      = rd_en && !rd_sel && !fifo_empty;
  assign doPush     = pushReq && (!fifo_full || doPop);
  assign overrunEvt = pushReq && fifo_full && !doPop;
  assign statusWord = {count, overrun, parityErr, frameErr, fifo_full, fifo_empty};
  assign err_any    = overrun | frameErr | parityErr;

  always_ff @(posedge sys_clk) begin
    if (doPush) mem[wrPtr] <= shiftReg;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      if (doPush && !doPop)      count <= count + CNT_W'(1);
      else if (doPop && !doPush) count <= count - CNT_W'(1);
    end
  end

  // Sticky flags: a new event outranks a same-cycle clear
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      overrun   <= 1'b0;
      frameErr  <= 1'b0;
      parityErr <= 1'b0;
    end else begin
      overrun   <= overrunEvt   | (overrun   & ~clr_err);
      frameErr  <= frameErrEvt  | (frameErr  & ~clr_err);
      parityErr <= parityErrEvt | (parityErr & ~clr_err);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (rd_sel)     rd_data <= OUT_WIDTH'(statusWord);
      else if (doPop) rd_data <= OUT_WIDTH'(mem[rdPtr]);
      else            rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_driver.sv
// Bench for uart_rx_fifo_driver: one plain instance and one with even parity,
// checked against a queue-based model of the receive path.
module tb_uart_rx_fifo_driver;

  localparam int CLK_FREQ = 100_000_000;
  localparam int UART_BPS = 1_000_000;
  localparam int BIT      = CLK_FREQ / UART_BPS;
  localparam int DEPTH    = 16;

  logic        clk = 1'b0;
  logic        rstN;
  logic        rxdA, rdEnA, rdSelA, clrA, emptyA, fullA, errA;
  logic        rxdB, rdEnB, rdSelB, clrB, emptyB, fullB, errB;
  logic [15:0] rdDataA, rdDataB;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  qA[$];
  logic [7:0]  qB[$];
  bit          ovr[2], fe[2], pe[2];
  int          calL, dummy;
  logic [15:0] simulRd;
  logic [7:0]  d, expRd;
  logic        s, p;

  uart_rx_fifo_driver #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8),
    .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .FIFO_DEPTH(DEPTH), .OUT_WIDTH(16)) dutA (
    .sys_clk(clk), .sys_rst_n(rstN), .uart_rxd(rxdA), .rd_en(rdEnA), .rd_sel(rdSelA),
    .clr_err(clrA), .rd_data(rdDataA), .fifo_empty(emptyA), .fifo_full(fullA), .err_any(errA));

  uart_rx_fifo_driver #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8),
    .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .FIFO_DEPTH(DEPTH), .OUT_WIDTH(16)) dutB (
    .sys_clk(clk), .sys_rst_n(rstN), .uart_rxd(rxdB), .rd_en(rdEnB), .rd_sel(rdSelB),
    .clr_err(clrB), .rd_data(rdDataB), .fifo_empty(emptyB), .fifo_full(fullB), .err_any(errB));

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qSize(input int sel);
    return (sel != 0) ? qB.size() : qA.size();
  endfunction

  function automatic logic [15:0] rdOf(input int sel);
    return (sel != 0) ? rdDataB : rdDataA;
  endfunction

  task automatic setRd(input int sel, input logic en, input logic rs);
    if (sel != 0) begin rdEnB = en; rdSelB = rs; end
    else          begin rdEnA = en; rdSelA = rs; end
  endtask

  // Drives one frame; optionally raises a data read for the cycle ending at edge rdEdge
  task automatic sendFrame(input int sel, input logic [7:0] data, input logic stopBit,
                           input logic parBit, input int rdEdge, output int firstFall);
    logic [10:0] fr;
    int nBits;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = data;
    if (sel != 0) begin fr[9] = parBit; fr[10] = stopBit; nBits = 11; end
    else          begin fr[9] = stopBit; nBits = 10; end
    firstFall = -1;
    for (int i = 0; i < nBits * BIT; i++) begin
      if (sel != 0) rxdB = fr[i / BIT];
      else          rxdA = fr[i / BIT];
      setRd(sel, (i + 1 == rdEdge), 1'b0);
      tick();
      if (i + 1 == rdEdge) simulRd = rdOf(sel);
      if (firstFall < 0 && ((sel != 0) ? !emptyB : !emptyA)) firstFall = i + 1;
    end
    if (sel != 0) rxdB = 1'b1;
    else          rxdA = 1'b1;
    setRd(sel, 1'b0, 1'b0);
    repeat (4) tick();
  endtask

  task automatic modelFrame(input int sel, input logic [7:0] data, input logic stopBit,
                            input logic parBit, input bit simulPop);
    bit parOk;
    parOk = 1'b1;
    if (sel != 0) begin
      parOk = (($countones(data) + int'(parBit)) % 2) == 0;
      if (!parOk) pe[sel] = 1'b1;
    end
    if (!stopBit) fe[sel] = 1'b1;
    else if (parOk) begin
      if (qSize(sel) == DEPTH && !simulPop) ovr[sel] = 1'b1;
      else if (sel != 0) qB.push_back(data);
      else qA.push_back(data);
    end
  endtask

  task automatic readData(input int sel, input string tag);
    logic [7:0] exp;
    exp = 8'h00;
    if (qSize(sel) > 0) exp = (sel != 0) ? qB.pop_front() : qA.pop_front();
    setRd(sel, 1'b1, 1'b0);
    tick();
    setRd(sel, 1'b0, 1'b0);
    check(tag, 32'(rdOf(sel)), 32'(exp));
  endtask

  task automatic readStatus(input int sel, input string tag);
    logic [9:0] exp;
    int n;
    n = qSize(sel);
    exp = {5'(n), ovr[sel], pe[sel], fe[sel], (n == DEPTH), (n == 0)};
    setRd(sel, 1'b1, 1'b1);
    tick();
    setRd(sel, 1'b0, 1'b0);
    check(tag, 32'(rdOf(sel)), 32'(exp));
  endtask

  task automatic checkPins(input int sel, input string tag);
    logic [2:0] obs;
    obs = (sel != 0) ? {emptyB, fullB, errB} : {emptyA, fullA, errA};
    check(tag, 32'(obs), 32'({qSize(sel) == 0, qSize(sel) == DEPTH, ovr[sel] | pe[sel] | fe[sel]}));
  endtask

  task automatic clearErr(input int sel);
    if (sel != 0) clrB = 1'b1;
    else          clrA = 1'b1;
    tick();
    clrA = 1'b0;
    clrB = 1'b0;
    ovr[sel] = 1'b0;
    pe[sel]  = 1'b0;
    fe[sel]  = 1'b0;
  endtask

  initial begin
    rstN = 1'b0;
    rxdA = 1'b1; rdEnA = 1'b0; rdSelA = 1'b0; clrA = 1'b0;
    rxdB = 1'b1; rdEnB = 1'b0; rdSelB = 1'b0; clrB = 1'b0;
    repeat (3) tick();
    check("reset_rd_data", 32'(rdDataA), 32'h0);
    checkPins(0, "reset_pins");
    rstN = 1'b1;
    repeat (3) tick();

    // Single byte; latency of the push after the start edge is recorded for later
    sendFrame(0, 8'hA5, 1'b1, 1'b0, 0, calL);
    modelFrame(0, 8'hA5, 1'b1, 1'b0, 1'b0);
    check("t1_push_edge_in_stop_bit", 32'(calL >= BIT * 19 / 2 && calL <= BIT * 19 / 2 + 6), 32'h1);
    checkPins(0, "t1_pins_after_push");
    readData(0, "t1_read_a5");
    checkPins(0, "t1_pins_after_read");

    // Overflow by one
    for (int b = 0; b < 17; b++) begin
      sendFrame(0, 8'(b), 1'b1, 1'b0, 0, dummy);
      modelFrame(0, 8'(b), 1'b1, 1'b0, 1'b0);
    end
    checkPins(0, "t2_pins_full");
    readStatus(0, "t2_status_full_overrun");
    for (int b = 0; b < 16; b++) readData(0, $sformatf("t2_read_%0d", b));
    readData(0, "t2_read_empty");
    readStatus(0, "t2_status_drained");
    clearErr(0);
    checkPins(0, "t2_pins_cleared");

    // Framing error
    sendFrame(0, 8'h3C, 1'b0, 1'b0, 0, dummy);
    modelFrame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    checkPins(0, "t3_pins_frame_err");
    readStatus(0, "t3_status_frame_err");
    clearErr(0);
    checkPins(0, "t3_pins_cleared");

    // Short low glitch, then a real frame to show the receiver is idle again
    rxdA = 1'b0;
    repeat (BIT * 3 / 10) tick();
    rxdA = 1'b1;
    repeat (2 * BIT) tick();
    checkPins(0, "t4_pins_after_glitch");
    readStatus(0, "t4_status_after_glitch");
    sendFrame(0, 8'h69, 1'b1, 1'b0, 0, dummy);
    modelFrame(0, 8'h69, 1'b1, 1'b0, 1'b0);
    readData(0, "t4_read_after_glitch");

    // Random frames, mostly good
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 4) != 0);
      sendFrame(0, d, s, 1'b0, 0, dummy);
      modelFrame(0, d, s, 1'b0, 1'b0);
    end
    readStatus(0, "rnd_status");
    checkPins(0, "rnd_pins");
    while (qA.size() > 0) readData(0, "rnd_read");
    readData(0, "rnd_read_empty");
    clearErr(0);

    // Even parity instance
    sendFrame(1, 8'h07, 1'b1, 1'b0, 0, dummy);
    modelFrame(1, 8'h07, 1'b1, 1'b0, 1'b0);
    readStatus(1, "t5_status_bad_parity");
    checkPins(1, "t5_pins_bad_parity");
    clearErr(1);
    sendFrame(1, 8'h07, 1'b1, 1'b1, 0, dummy);
    modelFrame(1, 8'h07, 1'b1, 1'b1, 1'b0);
    readStatus(1, "t5_status_good_parity");
    readData(1, "t5_read_07");
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      sendFrame(1, d, 1'b1, p, 0, dummy);
      modelFrame(1, d, 1'b1, p, 1'b0);
    end
    readStatus(1, "t5_rnd_status");
    while (qB.size() > 0) readData(1, "t5_rnd_read");
    clearErr(1);

    // Full FIFO with a data read landing on the stop-sample cycle
    for (int b = 0; b < 16; b++) begin
      sendFrame(0, 8'h80 + 8'(b), 1'b1, 1'b0, 0, dummy);
      modelFrame(0, 8'h80 + 8'(b), 1'b1, 1'b0, 1'b0);
    end
    checkPins(0, "t6_pins_full");
    expRd = qA.pop_front();
    sendFrame(0, 8'h77, 1'b1, 1'b0, calL, dummy);
    modelFrame(0, 8'h77, 1'b1, 1'b0, 1'b1);
    check("t6_simul_read_data", 32'(simulRd), 32'(expRd));
    readStatus(0, "t6_status_no_overrun");
    checkPins(0, "t6_pins_still_full");

    // Reset in the middle of a frame
    rxdA = 1'b0;
    repeat (3 * BIT) tick();
    rstN = 1'b0;
    #1;
    check("t6_reset_rd_data", 32'(rdDataA), 32'h0);
    qA.delete();
    qB.delete();
    ovr = '{default: 1'b0};
    pe  = '{default: 1'b0};
    fe  = '{default: 1'b0};
    checkPins(0, "t6_reset_pins");
    rxdA = 1'b1;
    repeat (5) tick();
    rstN = 1'b1;
    repeat (5) tick();
    sendFrame(0, 8'h5A, 1'b1, 1'b0, 0, dummy);
    modelFrame(0, 8'h5A, 1'b1, 1'b0, 1'b0);
    readStatus(0, "t6_status_after_reset");
    readData(0, "t6_read_5a");
    checkPins(0, "t6_pins_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
